// File: rtl/pipelined_barrel_rotator.sv
// Pipelined N-bit rotator / logical shifter with valid/ready handshakes.
// Stage k applies a shift of 2^k when amt bit k is set; stalls collapse bubbles.
module pipelined_barrel_rotator #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arg_vld,
    output logic          arg_rdy,
    input  logic [N-1:0]  arg,
    input  logic [SW-1:0] amt,
    input  logic [1:0]    mode,
    output logic          res_vld,
    input  logic          res_rdy,
    output logic [N-1:0]  res
);

    logic [SW-1:0]          vld_q, vld_d, ld;
    logic [SW-1:0][N-1:0]   data_q, data_d;
    logic [SW-1:0][SW-1:0]  amt_q, amt_d;
    logic [SW-1:0][1:0]     mode_q, mode_d;

    generate
        for (genvar gi = 0; gi < SW; gi++) begin : g_stage
            localparam int S = 1 << gi;
            logic          in_vld;
            logic [N-1:0]  in_data;
            logic [N-1:0]  shifted;
            logic [SW-1:0] in_amt;
            logic [1:0]    in_mode;

            if (gi == 0) begin : g_head
                assign in_vld  = arg_vld;
                assign in_data = arg;
                assign in_amt  = amt;
                assign in_mode = mode;
            end else begin : g_body
                assign in_vld  = vld_q[gi-1];
                assign in_data = data_q[gi-1];
                assign in_amt  = amt_q[gi-1];
                assign in_mode = mode_q[gi-1];
            end

            // A stage can load if the output is draining or any stage from here
            // to the end is empty; written flat to keep the ready chain acyclic.
            assign ld[gi] = res_rdy || !(&vld_q[SW-1:gi]);

            always_comb begin
                shifted = in_data;
                if (in_amt[gi]) begin
                    case (in_mode)
                        2'b00:   shifted = (in_data << S) | (in_data >> (N - S));
                        2'b01:   shifted = (in_data >> S) | (in_data << (N - S));
                        2'b10:   shifted = in_data << S;
                        default: shifted = in_data >> S;
                    endcase
                end
            end

            // Payload only moves with a valid token so an emptied stage keeps its last value.
            assign vld_d[gi]  = ld[gi] ? in_vld : vld_q[gi];
            assign data_d[gi] = (ld[gi] && in_vld) ? shifted : data_q[gi];
            assign amt_d[gi]  = (ld[gi] && in_vld) ? in_amt  : amt_q[gi];
            assign mode_d[gi] = (ld[gi] && in_vld) ? in_mode : mode_q[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            data_q <= '0;
            amt_q  <= '0;
            mode_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            amt_q  <= amt_d;
            mode_q <= mode_d;
        end
    end

    // The last stage's control fields ride along but nothing downstream needs them.
    logic unused_tail;
    assign unused_tail = ^{amt_q[SW-1], mode_q[SW-1]};

    assign arg_rdy = ld[0];
    assign res_vld = vld_q[SW-1];
    assign res     = data_q[SW-1];

endmodule

// File: tb/tb_pipelined_barrel_rotator.sv
// Scoreboard bench for pipelined_barrel_rotator: stimulus pushes expected results,
// a negedge monitor pops and compares whenever an output transfer is about to happen.
module tb_pipelined_barrel_rotator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arg_vld = 1'b0;
    logic       arg_rdy;
    logic [7:0] arg = '0;
    logic [2:0] amt = '0;
    logic [1:0] mode = '0;
    logic       res_vld;
    logic       res_rdy = 1'b1;
    logic [7:0] res;

    logic        arg_vld32 = 1'b0;
    logic        arg_rdy32;
    logic [31:0] arg32 = '0;
    logic [4:0]  amt32 = '0;
    logic [1:0]  mode32 = '0;
    logic        res_vld32;
    logic        res_rdy32 = 1'b1;
    logic [31:0] res32;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    bit rnd_mode = 1'b0;

    typedef struct {
        logic [7:0] data;
        int         edge_c;
        bit         chk_lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_barrel_rotator #(.N(8)) u_dut (
        .clk(clk), .rst(rst),
        .arg_vld(arg_vld), .arg_rdy(arg_rdy), .arg(arg), .amt(amt), .mode(mode),
        .res_vld(res_vld), .res_rdy(res_rdy), .res(res)
    );

    pipelined_barrel_rotator #(.N(32)) u_dut32 (
        .clk(clk), .rst(rst),
        .arg_vld(arg_vld32), .arg_rdy(arg_rdy32), .arg(arg32), .amt(amt32), .mode(mode32),
        .res_vld(res_vld32), .res_rdy(res_rdy32), .res(res32)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Single-bit steps, independent of the power-of-two stage decomposition.
    function automatic logic [7:0] ref_shift(input logic [7:0] a, input int s, input logic [1:0] m);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < s; i++) begin
            case (m)
                2'b00:   r = {r[6:0], r[7]};
                2'b01:   r = {r[0], r[7:1]};
                2'b10:   r = {r[6:0], 1'b0};
                default: r = {1'b0, r[7:1]};
            endcase
        end
        return r;
    endfunction

    // Monitor: a transfer happens at the next posedge when res_vld && res_rdy now.
    always @(negedge clk) begin
        if (!rst && res_vld && res_rdy) begin
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected_result: got %h, expected no output", res);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("[TB] result %h expected %h", res, e.data);
                chk("res", {24'h0, res}, {24'h0, e.data});
                if (e.chk_lat) chk("latency", cyc + 1 - e.edge_c, 3);
            end
        end
    end

    // Offer one transaction and hold it until accepted; exp_rdy < 0 skips the first-cycle ready check.
    task automatic send(input logic [7:0] a, input logic [2:0] s, input logic [1:0] m,
                        input logic [7:0] exp, input bit lat, input int exp_rdy);
        bit acc;
        arg = a; amt = s; mode = m; arg_vld = 1'b1;
        acc = 1'b0;
        for (int w = 0; w < 200 && !acc; w++) begin
            @(negedge clk);
            if (w == 0 && exp_rdy >= 0) chk("arg_rdy", {31'h0, arg_rdy}, exp_rdy);
            if (arg_rdy) begin
                sb.push_back('{data: exp, edge_c: cyc + 1, chk_lat: lat});
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!acc && rnd_mode) res_rdy = 1'($urandom_range(0, 1));
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        arg_vld = 1'b0;
    endtask

    task automatic drain();
        res_rdy = 1'b1;
        for (int w = 0; w < 100 && (sb.size() != 0 || res_vld); w++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        logic [7:0] one_hot;
        #1;
        chk("reset_res_vld", {31'h0, res_vld}, 0);
        chk("reset_res", {24'h0, res}, 0);
        chk("reset_arg_rdy", {31'h0, arg_rdy}, 1);
        chk("reset_res_vld32", {31'h0, res_vld32}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // One transfer per mode, E5 by 3.
        send(8'hE5, 3'd3, 2'b01, 8'hBC, 1'b1, 1);
        send(8'hE5, 3'd3, 2'b00, 8'h2F, 1'b1, 1);
        send(8'hE5, 3'd3, 2'b11, 8'h1C, 1'b1, 1);
        send(8'hE5, 3'd3, 2'b10, 8'h28, 1'b1, 1);
        drain();

        // Back-to-back walking one.
        for (int i = 0; i < 8; i++) begin
            one_hot = 8'h01 << i;
            send(8'h01, 3'(i), 2'b00, one_hot, 1'b1, 1);
        end
        drain();

        // Backpressure: three fill the pipe, the fourth waits.
        res_rdy = 1'b0;
        send(8'hE5, 3'd1, 2'b01, 8'hF2, 1'b0, 1);
        send(8'h81, 3'd1, 2'b01, 8'hC0, 1'b0, 1);
        send(8'h0F, 3'd1, 2'b01, 8'h87, 1'b0, 1);
        arg = 8'h3C; amt = 3'd1; mode = 2'b01; arg_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_arg_rdy", {31'h0, arg_rdy}, 0);
            chk("stall_res_vld", {31'h0, res_vld}, 1);
            chk("stall_res", {24'h0, res}, 32'hF2);
            @(posedge clk);
            #1;
        end
        res_rdy = 1'b1;
        send(8'h3C, 3'd1, 2'b01, 8'h1E, 1'b0, 1);
        drain();

        // amt = 0 is the identity in every mode.
        for (int m = 0; m < 4; m++) send(8'hA7, 3'd0, 2'(m), 8'hA7, 1'b1, 1);
        drain();

        // Reset with two transactions in flight, asserted between clock edges.
        res_rdy = 1'b0;
        send(8'h11, 3'd1, 2'b00, 8'h22, 1'b0, 1);
        send(8'h22, 3'd1, 2'b00, 8'h44, 1'b0, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_res_vld", {31'h0, res_vld}, 0);
        chk("async_rst_res", {24'h0, res}, 0);
        sb.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        res_rdy = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_idle", {31'h0, res_vld}, 0);
        end
        @(posedge clk);
        #1;
        send(8'hC3, 3'd2, 2'b01, 8'hF0, 1'b1, 1);
        drain();

        // Random traffic with random backpressure against the bit-step model.
        rnd_mode = 1'b1;
        for (int i = 0; i < 150; i++) begin
            logic [7:0] a;
            logic [2:0] s;
            logic [1:0] m;
            res_rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) begin
                a = 8'($urandom);
                s = 3'($urandom);
                m = 2'($urandom);
                send(a, s, m, ref_shift(a, int'(s), m), 1'b0, -1);
            end else begin
                @(posedge clk);
                #1;
            end
        end
        rnd_mode = 1'b0;
        drain();

        // 32-bit build: rotate left by 31.
        begin
            int cnt;
            arg32 = 32'h8000_0001; amt32 = 5'd31; mode32 = 2'b00; arg_vld32 = 1'b1;
            @(negedge clk);
            chk("arg_rdy32", {31'h0, arg_rdy32}, 1);
            @(posedge clk);
            #1 arg_vld32 = 1'b0;
            cnt = 0;
            for (int w = 0; w < 20; w++) begin
                @(negedge clk);
                cnt++;
                if (res_vld32) break;
            end
            $display("[TB] result32 %h expected c0000000 after %0d cycles", res32, cnt);
            chk("latency32", cnt, 5);
            chk("res32", res32, 32'hC000_0000);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
